fpu_dispatcher: RTL

//  Initiator side of the fixed-point unit interface (operand_1/operand_2/operation -> result/ready).

---
 rtl/fpu_dispatcher_pkg.sv | 22 ++
 rtl/fpu_dispatcher.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fpu_dispatcher_pkg.sv
// Shared definitions for the fixed-point unit dispatcher: FPU operation codes,
// FSM state encoding and small decode helpers.
package fpu_dispatcher_pkg;

   localparam logic [1:0] FPU_ADD  = 2'b00;
   localparam logic [1:0] FPU_SUB  = 2'b01;
   localparam logic [1:0] FPU_MUL  = 2'b10;
   localparam logic [1:0] FPU_SQRT = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // MUL and SQRT are sequential inside the FPU and answer through ready.
   function automatic logic is_multicycle(input logic [1:0] op);
      return (op == FPU_MUL) || (op == FPU_SQRT);
   endfunction

endpackage

// File: rtl/fpu_dispatcher.sv
// Initiator side of the fixed-point unit interface: one tagged request at a time,
// FPU inputs held stable until the unit answers, bounded wait, one-cycle write-back.
module fpu_dispatcher
   import fpu_dispatcher_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int FBITS   = 10,
   parameter int TAG_W   = 5,
   parameter int MIN_LAT = 2,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic [WIDTH-1:0] fpu_operand_1,
   output logic [WIDTH-1:0] fpu_operand_2,
   output logic [1:0]       fpu_operation,
   input  logic [WIDTH-1:0] fpu_result,
   input  logic             fpu_ready,
   output logic             wb_valid,
   output logic [WIDTH-1:0] wb_result,
   output logic [TAG_W-1:0] wb_tag,
   output logic             wb_error,
   output logic             busy
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   if (TIMEOUT <= MIN_LAT || FBITS >= WIDTH) begin : g_bad_params
      $error("fpu_dispatcher: need TIMEOUT > MIN_LAT and FBITS < WIDTH");
   end

   state_t           state_p0;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt_p0;
   logic [TAG_W-1:0] tag_p0;
   logic             multi;
   logic             honour;
   logic             expired;

   assign multi   = is_multicycle(fpu_operation);
   // A ready seen before MIN_LAT is the previous product's flag, not ours.
   assign honour  = fpu_ready && (cnt_p0 >= CNT_W'(MIN_LAT));
   assign expired = (cnt_p0 == CNT_W'(TIMEOUT));

   assign req_ready = (state_p0 == S_IDLE);
   assign busy      = (state_p0 != S_IDLE);
   assign wb_valid  = (state_p0 == S_RESP);
   assign wb_tag    = tag_p0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_p0 <= S_IDLE;
      else       state_p0 <= state_nxt;
   end

   always_comb begin
      state_nxt = state_p0;
      case (state_p0)
         S_IDLE:  if (req_valid) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = multi ? S_WAIT : S_RESP;
         S_WAIT:  if (honour || expired) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---- request latch / FPU drive / write-back capture ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fpu_operand_1 <= '0;
         fpu_operand_2 <= '0;
         fpu_operation <= FPU_ADD;
         tag_p0        <= '0;
         cnt_p0        <= '0;
         wb_result     <= '0;
         wb_error      <= 1'b0;
      end else begin
         case (state_p0)
            S_IDLE: begin
               if (req_valid) begin
                  fpu_operand_1 <= req_a;
                  fpu_operand_2 <= req_b;
                  fpu_operation <= req_op;
                  tag_p0        <= req_tag;
                  cnt_p0        <= '0;
               end
            end
            S_ISSUE: begin
               if (multi) begin
                  cnt_p0 <= CNT_W'(1);
               end else begin
                  wb_result <= fpu_result;
                  wb_error  <= 1'b0;
               end
            end
            S_WAIT: begin
               if (honour) begin
                  wb_result <= fpu_result;
                  wb_error  <= 1'b0;
               end else if (expired) begin
                  wb_result <= '0;
                  wb_error  <= 1'b1;
               end else begin
                  cnt_p0 <= cnt_p0 + CNT_W'(1);
               end
            end
            S_RESP: begin
               // Park the FPU on a harmless ADD of zeros so its sequential units stay idle.
               fpu_operand_1 <= '0;
               fpu_operand_2 <= '0;
               fpu_operation <= FPU_ADD;
            end
            default: ;
         endcase
      end
   end

endmodule
